sr_frame_sequencer: RTL and testbench

//  Parametrised frame controller for the I/Q classification chain: CORDIC -> sort chain -> DBSCAN abs/arg -> MLP.

---
 rtl/sr_frame_sequencer_pkg.sv | 29 ++
 rtl/sr_frame_sequencer_watchdog.sv | 31 +++
 rtl/sr_frame_sequencer.sv | 173 +++++++++++++++++
 tb/tb_sr_frame_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_frame_sequencer_pkg.sv
// Shared state encoding, error codes and default sizes for the I/Q frame sequencer.
package sr_frame_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COLLECT   = 3'd1,
    ST_SORT_WAIT = 3'd2,
    ST_CLUSTER   = 3'd3,
    ST_CLASSIFY  = 3'd4,
    ST_RESULT    = 3'd5
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_SORT = 2'd1;
  localparam logic [1:0] ERR_CLUS = 2'd2;
  localparam logic [1:0] ERR_MLP  = 2'd3;

  localparam int DEF_N_SAMPLES = 1000;
  localparam int DEF_FEAT_W    = 10;
  localparam int DEF_FRAC_W    = 7;
  localparam int DEF_RESULT_W  = 24;
  localparam int DEF_CLASS_W   = 4;
  localparam int DEF_TIMEOUT   = 65535;

  function automatic logic is_wait_state(input state_t s);
    return (s == ST_SORT_WAIT) || (s == ST_CLUSTER) || (s == ST_CLASSIFY);
  endfunction

endpackage

// File: rtl/sr_frame_sequencer_watchdog.sv
// Cycle counter for the wait states; expired flags the TIMEOUT-th cycle spent in a state.
module sr_frame_sequencer_watchdog
  import sr_frame_sequencer_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + WD_W'(1);
    end
  end

  // r_cnt holds the number of completed cycles, so TIMEOUT-1 marks the TIMEOUT-th one
  assign o_expired = i_en && (r_cnt == WD_W'(TIMEOUT - 1));

endmodule

// File: rtl/sr_frame_sequencer.sv
// Frame controller: collects a feature frame, sequences sort/DBSCAN/MLP and holds the result.
module sr_frame_sequencer
  import sr_frame_sequencer_pkg::*;
#(
  parameter int N_SAMPLES  = DEF_N_SAMPLES,
  parameter int FEAT_W     = DEF_FEAT_W,
  parameter int FRAC_W     = DEF_FRAC_W,
  parameter int RESULT_W   = DEF_RESULT_W,
  parameter int CLASS_W    = DEF_CLASS_W,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int AUTO_REARM = 0
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic                i_s_valid,
  output logic                o_s_ready,
  input  logic [FEAT_W-1:0]   i_s_abs,
  input  logic [FEAT_W-1:0]   i_s_arg,
  output logic                o_sort_valid,
  output logic [FEAT_W-1:0]   o_sort_abs,
  output logic [FEAT_W-1:0]   o_sort_arg,
  output logic                o_sort_last,
  input  logic                i_sort_final,
  output logic                o_clus_start,
  input  logic                i_clus_done,
  input  logic [FEAT_W-1:0]   i_clus_abs,
  input  logic [FEAT_W-1:0]   i_clus_arg,
  output logic                o_mlp_en,
  output logic [RESULT_W-1:0] o_mlp_in0,
  output logic [RESULT_W-1:0] o_mlp_in1,
  input  logic                i_mlp_done,
  input  logic [CLASS_W-1:0]  i_mlp_class,
  input  logic [RESULT_W-1:0] i_mlp_reg,
  output logic                o_res_valid,
  input  logic                i_res_ready,
  output logic [CLASS_W-1:0]  o_res_class,
  output logic [RESULT_W-1:0] o_res_reg,
  output logic [7:0]          o_res_frame,
  output logic                o_busy,
  output logic [1:0]          o_err_code
);

  localparam int CNT_W = $clog2(N_SAMPLES);

  if (FEAT_W + FRAC_W > RESULT_W) begin : g_width_check
    $error("FEAT_W + FRAC_W must not exceed RESULT_W");
  end

  function automatic logic [RESULT_W-1:0] pack_feat(input logic [FEAT_W-1:0] f);
    logic [RESULT_W-1:0] v;
    v = '0;
    v[FEAT_W+FRAC_W-1:FRAC_W] = f;
    return v;
  endfunction

  state_t              r_state;
  state_t              w_nxt;
  logic [1:0]          r_err;
  logic [1:0]          w_err_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [7:0]          r_frame;
  logic                r_s_ready, r_busy, r_mlp_en, r_res_valid;
  logic                r_sort_valid, r_sort_last, r_clus_start;
  logic [FEAT_W-1:0]   r_sort_abs, r_sort_arg, r_clus_abs, r_clus_arg;
  logic [CLASS_W-1:0]  r_res_class;
  logic [RESULT_W-1:0] r_res_reg;
  logic                w_accept, w_last_beat, w_clus_ok, w_expired;

  assign w_accept    = r_s_ready && i_s_valid && !i_abort;
  assign w_last_beat = w_accept && (r_cnt == CNT_W'(N_SAMPLES - 1));
  // clus_start is high exactly on the first CLUSTER cycle, when done is not yet trusted
  assign w_clus_ok   = i_clus_done && !r_clus_start;

  sr_frame_sequencer_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clear   (w_nxt != r_state),
    .i_en      (is_wait_state(r_state)),
    .o_expired (w_expired)
  );

  always_comb begin
    w_nxt     = r_state;
    w_err_nxt = r_err;
    if (i_abort) begin
      w_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:      if (i_start) begin w_nxt = ST_COLLECT; w_err_nxt = ERR_NONE; end
        ST_COLLECT:   if (w_last_beat) w_nxt = ST_SORT_WAIT;
        ST_SORT_WAIT: if (i_sort_final) w_nxt = ST_CLUSTER;
                      else if (w_expired) begin w_nxt = ST_IDLE; w_err_nxt = ERR_SORT; end
        ST_CLUSTER:   if (w_clus_ok) w_nxt = ST_CLASSIFY;
                      else if (w_expired) begin w_nxt = ST_IDLE; w_err_nxt = ERR_CLUS; end
        ST_CLASSIFY:  if (i_mlp_done) w_nxt = ST_RESULT;
                      else if (w_expired) begin w_nxt = ST_IDLE; w_err_nxt = ERR_MLP; end
        ST_RESULT:    if (i_res_ready) w_nxt = (AUTO_REARM != 0) ? ST_COLLECT : ST_IDLE;
        default:      w_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_err        <= ERR_NONE;
      r_cnt        <= '0;
      r_frame      <= '0;
      r_s_ready    <= 1'b0;
      r_busy       <= 1'b0;
      r_mlp_en     <= 1'b0;
      r_res_valid  <= 1'b0;
      r_sort_valid <= 1'b0;
      r_sort_last  <= 1'b0;
      r_clus_start <= 1'b0;
      r_sort_abs   <= '0;
      r_sort_arg   <= '0;
      r_clus_abs   <= '0;
      r_clus_arg   <= '0;
      r_res_class  <= '0;
      r_res_reg    <= '0;
    end else begin
      r_state      <= w_nxt;
      r_err        <= w_err_nxt;
      r_s_ready    <= (w_nxt == ST_COLLECT);
      r_busy       <= (w_nxt != ST_IDLE);
      r_mlp_en     <= (w_nxt == ST_CLASSIFY);
      r_res_valid  <= (w_nxt == ST_RESULT);
      r_sort_valid <= w_accept;
      r_sort_last  <= w_last_beat;
      r_clus_start <= (w_nxt == ST_CLUSTER) && (r_state != ST_CLUSTER);
      if (w_accept) begin
        r_sort_abs <= i_s_abs;
        r_sort_arg <= i_s_arg;
      end
      if (i_abort || w_last_beat) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (r_state == ST_CLUSTER && w_nxt == ST_CLASSIFY) begin
        r_clus_abs <= i_clus_abs;
        r_clus_arg <= i_clus_arg;
      end
      if (r_state == ST_CLASSIFY && w_nxt == ST_RESULT) begin
        r_res_class <= i_mlp_class;
        r_res_reg   <= i_mlp_reg;
      end
      if (r_state == ST_RESULT && i_res_ready && !i_abort) begin
        r_frame <= r_frame + 8'd1;
      end
    end
  end

  assign o_s_ready    = r_s_ready;
  assign o_busy       = r_busy;
  assign o_mlp_en     = r_mlp_en;
  assign o_res_valid  = r_res_valid;
  assign o_sort_valid = r_sort_valid;
  assign o_sort_last  = r_sort_last;
  assign o_sort_abs   = r_sort_abs;
  assign o_sort_arg   = r_sort_arg;
  assign o_clus_start = r_clus_start;
  assign o_mlp_in0    = pack_feat(r_clus_arg);
  assign o_mlp_in1    = pack_feat(r_clus_abs);
  assign o_res_class  = r_res_class;
  assign o_res_reg    = r_res_reg;
  assign o_res_frame  = r_frame;
  assign o_err_code   = r_err;

endmodule

// File: tb/tb_sr_frame_sequencer.sv
// Bench for sr_frame_sequencer: behavioural frame model checked every cycle, directed and random stimulus.
module tb_sr_frame_sequencer;

  localparam int N  = 8;
  localparam int FW = 10;
  localparam int RW = 24;
  localparam int CW = 4;
  localparam int TO = 20;

  localparam int M_IDLE = 0, M_COLLECT = 1, M_SORTW = 2, M_CLUS = 3, M_CLASS = 4, M_RESULT = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_start = 0, in_abort = 0, in_s_valid = 0, in_sort_final = 0;
  logic in_clus_done = 0, in_mlp_done = 0, in_res_ready = 0;
  logic [FW-1:0] in_s_abs = '0, in_s_arg = '0, in_clus_abs = '0, in_clus_arg = '0;
  logic [CW-1:0] in_mlp_class = '0;
  logic [RW-1:0] in_mlp_reg = '0;

  logic o_s_ready, o_sort_valid, o_sort_last, o_clus_start, o_mlp_en, o_res_valid, o_busy;
  logic [FW-1:0] o_sort_abs, o_sort_arg;
  logic [RW-1:0] o_mlp_in0, o_mlp_in1, o_res_reg;
  logic [CW-1:0] o_res_class;
  logic [7:0]    o_res_frame;
  logic [1:0]    o_err_code;

  logic a_s_ready, a_sort_valid, a_sort_last, a_clus_start, a_mlp_en, a_res_valid, a_busy;
  logic [FW-1:0] a_sort_abs, a_sort_arg;
  logic [RW-1:0] a_mlp_in0, a_mlp_in1, a_res_reg;
  logic [CW-1:0] a_res_class;
  logic [7:0]    a_res_frame;
  logic [1:0]    a_err_code;

  sr_frame_sequencer #(.N_SAMPLES(N), .FEAT_W(FW), .FRAC_W(7), .RESULT_W(RW), .CLASS_W(CW),
                       .TIMEOUT(TO), .AUTO_REARM(0)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(in_start), .i_abort(in_abort),
    .i_s_valid(in_s_valid), .o_s_ready(o_s_ready), .i_s_abs(in_s_abs), .i_s_arg(in_s_arg),
    .o_sort_valid(o_sort_valid), .o_sort_abs(o_sort_abs), .o_sort_arg(o_sort_arg),
    .o_sort_last(o_sort_last), .i_sort_final(in_sort_final), .o_clus_start(o_clus_start),
    .i_clus_done(in_clus_done), .i_clus_abs(in_clus_abs), .i_clus_arg(in_clus_arg),
    .o_mlp_en(o_mlp_en), .o_mlp_in0(o_mlp_in0), .o_mlp_in1(o_mlp_in1), .i_mlp_done(in_mlp_done),
    .i_mlp_class(in_mlp_class), .i_mlp_reg(in_mlp_reg), .o_res_valid(o_res_valid),
    .i_res_ready(in_res_ready), .o_res_class(o_res_class), .o_res_reg(o_res_reg),
    .o_res_frame(o_res_frame), .o_busy(o_busy), .o_err_code(o_err_code));

  sr_frame_sequencer #(.N_SAMPLES(N), .FEAT_W(FW), .FRAC_W(7), .RESULT_W(RW), .CLASS_W(CW),
                       .TIMEOUT(TO), .AUTO_REARM(1)) u_dut_ar (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(in_start), .i_abort(in_abort),
    .i_s_valid(in_s_valid), .o_s_ready(a_s_ready), .i_s_abs(in_s_abs), .i_s_arg(in_s_arg),
    .o_sort_valid(a_sort_valid), .o_sort_abs(a_sort_abs), .o_sort_arg(a_sort_arg),
    .o_sort_last(a_sort_last), .i_sort_final(in_sort_final), .o_clus_start(a_clus_start),
    .i_clus_done(in_clus_done), .i_clus_abs(in_clus_abs), .i_clus_arg(in_clus_arg),
    .o_mlp_en(a_mlp_en), .o_mlp_in0(a_mlp_in0), .o_mlp_in1(a_mlp_in1), .i_mlp_done(in_mlp_done),
    .i_mlp_class(in_mlp_class), .i_mlp_reg(in_mlp_reg), .o_res_valid(a_res_valid),
    .i_res_ready(in_res_ready), .o_res_class(a_res_class), .o_res_reg(a_res_reg),
    .o_res_frame(a_res_frame), .o_busy(a_busy), .o_err_code(a_err_code));

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase of the frame plus what each output must show
  int            m_ph, m_beats, m_wait;
  logic [7:0]    m_frame;
  logic [1:0]    m_err;
  logic [FW-1:0] m_cabs, m_carg, e_sabs, e_sarg;
  logic [CW-1:0] m_cls;
  logic [RW-1:0] m_reg;
  logic          e_sv, e_sl, e_cs;

  task automatic model_reset();
    m_ph = M_IDLE; m_beats = 0; m_wait = 0; m_frame = '0; m_err = '0;
    m_cabs = '0; m_carg = '0; m_cls = '0; m_reg = '0;
    e_sabs = '0; e_sarg = '0; e_sv = 0; e_sl = 0; e_cs = 0;
  endtask

  task automatic model_step();
    e_sv = 0; e_sl = 0; e_cs = 0;
    if (in_abort) begin
      m_ph = M_IDLE; m_beats = 0; m_wait = 0;
    end else begin
      case (m_ph)
        M_IDLE: if (in_start) begin m_ph = M_COLLECT; m_err = 0; end
        M_COLLECT: if (in_s_valid) begin
          e_sv = 1; e_sabs = in_s_abs; e_sarg = in_s_arg; m_beats++;
          if (m_beats == N) begin e_sl = 1; m_beats = 0; m_wait = 0; m_ph = M_SORTW; end
        end
        M_SORTW: begin
          m_wait++;
          if (in_sort_final) begin m_ph = M_CLUS; m_wait = 0; e_cs = 1; end
          else if (m_wait == TO) begin m_ph = M_IDLE; m_err = 2'd1; end
        end
        M_CLUS: begin
          m_wait++;
          if (in_clus_done && m_wait > 1) begin
            m_cabs = in_clus_abs; m_carg = in_clus_arg; m_ph = M_CLASS; m_wait = 0;
          end else if (m_wait == TO) begin m_ph = M_IDLE; m_err = 2'd2; end
        end
        M_CLASS: begin
          m_wait++;
          if (in_mlp_done) begin m_cls = in_mlp_class; m_reg = in_mlp_reg; m_ph = M_RESULT; end
          else if (m_wait == TO) begin m_ph = M_IDLE; m_err = 2'd3; end
        end
        M_RESULT: if (in_res_ready) begin m_frame = m_frame + 8'd1; m_ph = M_IDLE; end
        default: m_ph = M_IDLE;
      endcase
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Every-cycle comparison of the main instance against the model
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("s_ready",    32'(o_s_ready),    32'(m_ph == M_COLLECT));
      chk("busy",       32'(o_busy),       32'(m_ph != M_IDLE));
      chk("mlp_en",     32'(o_mlp_en),     32'(m_ph == M_CLASS));
      chk("res_valid",  32'(o_res_valid),  32'(m_ph == M_RESULT));
      chk("sort_valid", 32'(o_sort_valid), 32'(e_sv));
      chk("sort_last",  32'(o_sort_last),  32'(e_sl));
      chk("sort_abs",   32'(o_sort_abs),   32'(e_sabs));
      chk("sort_arg",   32'(o_sort_arg),   32'(e_sarg));
      chk("clus_start", 32'(o_clus_start), 32'(e_cs));
      chk("mlp_in0",    32'(o_mlp_in0),    32'(m_carg) * 128);
      chk("mlp_in1",    32'(o_mlp_in1),    32'(m_cabs) * 128);
      chk("res_class",  32'(o_res_class),  32'(m_cls));
      chk("res_reg",    32'(o_res_reg),    32'(m_reg));
      chk("res_frame",  32'(o_res_frame),  32'(m_frame));
      chk("err_code",   32'(o_err_code),   32'(m_err));
    end
  end

  // Event log used by the directed literal checks
  logic [FW-1:0] sv_q[$];
  int n_last = 0, n_cs = 0, n_rv = 0;
  logic [FW-1:0] last_abs = '0;
  initial forever begin
    @(negedge clk);
    if (o_sort_valid) sv_q.push_back(o_sort_abs);
    if (o_sort_last) begin n_last++; last_abs = o_sort_abs; end
    if (o_clus_start) n_cs++;
    if (o_res_valid) n_rv++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    in_start = 1; tick(); in_start = 0;
  endtask

  task automatic feed_beats(input int base, input int cnt);
    for (int i = 1; i <= cnt; i++) begin
      in_s_valid = 1; in_s_abs = FW'(base + i); in_s_arg = FW'(N - i); tick();
    end
    in_s_valid = 0;
  endtask

  task automatic pulse_sort_final(input int delay);
    repeat (delay - 1) tick();
    in_sort_final = 1; tick(); in_sort_final = 0;
  endtask

  task automatic do_cluster(input logic [FW-1:0] ca, input logic [FW-1:0] cg);
    tick(); tick();
    in_clus_abs = ca; in_clus_arg = cg; in_clus_done = 1; tick(); in_clus_done = 0;
  endtask

  task automatic do_mlp(input logic [CW-1:0] c, input logic [RW-1:0] r);
    in_mlp_class = c; in_mlp_reg = r; in_mlp_done = 1; tick(); in_mlp_done = 0;
  endtask

  task automatic handshake();
    in_res_ready = 1; tick(); in_res_ready = 0;
  endtask

  task automatic run_random(input int cycles, input int pdone);
    for (int c = 0; c < cycles; c++) begin
      in_start      = ($urandom_range(0, 3) == 0);
      in_abort      = ($urandom_range(0, 63) == 0);
      in_s_valid    = 1'($urandom_range(0, 1));
      in_s_abs      = FW'($urandom_range(0, 1023));
      in_s_arg      = FW'($urandom_range(0, 1023));
      in_sort_final = ($urandom_range(0, pdone - 1) == 0);
      in_clus_done  = ($urandom_range(0, pdone - 1) == 0);
      in_clus_abs   = FW'($urandom_range(0, 1023));
      in_clus_arg   = FW'($urandom_range(0, 1023));
      in_mlp_done   = ($urandom_range(0, pdone - 1) == 0);
      in_mlp_class  = CW'($urandom_range(0, 15));
      in_mlp_reg    = RW'($urandom_range(0, 32'hFFFFFF));
      in_res_ready  = ($urandom_range(0, 2) == 0);
      tick();
    end
    in_start = 0; in_abort = 0; in_s_valid = 0; in_sort_final = 0;
    in_clus_done = 0; in_mlp_done = 0; in_res_ready = 0;
  endtask

  int base_sv, base_last, base_cs, base_rv, n;

  initial begin
    rst_n = 0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1;
    chk_en = 1;
    chk("reset_busy", 32'(o_busy), 32'd0);
    chk("reset_s_ready", 32'(o_s_ready), 32'd0);
    chk("reset_res_frame", 32'(o_res_frame), 32'd0);
    chk("reset_err", 32'(o_err_code), 32'd0);
    tick();

    // Nominal frame
    base_sv = sv_q.size(); base_last = n_last; base_cs = n_cs;
    do_start();
    feed_beats(0, N);
    pulse_sort_final(5);
    do_cluster(10'h155, 10'h0AA);
    chk("t1_mlp_en", 32'(o_mlp_en), 32'd1);
    chk("t1_mlp_in0", 32'(o_mlp_in0), 32'h005500);
    chk("t1_mlp_in1", 32'(o_mlp_in1), 32'h00AA80);
    do_mlp(4'd3, 24'h00ABCD);
    chk("t1_res_valid", 32'(o_res_valid), 32'd1);
    chk("t1_res_class", 32'(o_res_class), 32'd3);
    chk("t1_res_reg", 32'(o_res_reg), 32'h00ABCD);
    chk("t1_res_frame", 32'(o_res_frame), 32'd0);
    handshake();
    chk("t1_idle", 32'(o_busy), 32'd0);
    chk("t1_sv_count", 32'(sv_q.size() - base_sv), 32'd8);
    chk("t1_last_count", 32'(n_last - base_last), 32'd1);
    chk("t1_last_abs", 32'(last_abs), 32'd8);
    chk("t1_clus_start_count", 32'(n_cs - base_cs), 32'd1);

    // Backpressure on both sides
    base_sv = sv_q.size(); base_last = n_last;
    do_start();
    for (int i = 0; i < 16; i++) begin
      in_s_valid = (i % 2 == 0); in_s_abs = FW'(200 + i); in_s_arg = FW'(i); tick();
    end
    in_s_valid = 0;
    pulse_sort_final(2);
    do_cluster(10'h3FF, 10'h001);
    do_mlp(4'd5, 24'h123456);
    for (int i = 0; i < 10; i++) begin
      chk("t2_res_valid", 32'(o_res_valid), 32'd1);
      chk("t2_res_class", 32'(o_res_class), 32'd5);
      chk("t2_res_reg", 32'(o_res_reg), 32'h123456);
      chk("t2_res_frame", 32'(o_res_frame), 32'd1);
      tick();
    end
    handshake();
    chk("t2_sv_count", 32'(sv_q.size() - base_sv), 32'd8);
    chk("t2_last_count", 32'(n_last - base_last), 32'd1);

    // Cluster timeout
    base_rv = n_rv;
    do_start();
    feed_beats(0, N);
    pulse_sort_final(1);
    n = 0;
    while (o_busy && n < 100) begin tick(); n++; end
    chk("t3_cluster_cycles", 32'(n), 32'd20);
    chk("t3_err_code", 32'(o_err_code), 32'd2);
    chk("t3_no_result", 32'(n_rv - base_rv), 32'd0);
    chk("t3_frame_kept", 32'(o_res_frame), 32'd2);
    do_start();
    chk("t3_err_cleared", 32'(o_err_code), 32'd0);

    // Abort mid-collect, then a fresh frame
    feed_beats(0, 5);
    in_abort = 1; tick(); in_abort = 0;
    chk("t4_abort_idle", 32'(o_busy), 32'd0);
    chk("t4_abort_s_ready", 32'(o_s_ready), 32'd0);
    base_sv = sv_q.size();
    do_start();
    feed_beats(100, N);
    pulse_sort_final(2);
    chk("t4_sv_count", 32'(sv_q.size() - base_sv), 32'd8);
    chk("t4_first_abs", 32'(sv_q[base_sv]), 32'd101);
    do_cluster(10'h011, 10'h022);
    do_mlp(4'd9, 24'h000777);
    chk("t4_res_frame", 32'(o_res_frame), 32'd2);
    handshake();

    // Asynchronous reset during CLASSIFY
    do_start();
    feed_beats(0, N);
    pulse_sort_final(3);
    do_cluster(10'h0F0, 10'h00F);
    chk("t6_pre_mlp_en", 32'(o_mlp_en), 32'd1);
    chk("t6_pre_frame", 32'(o_res_frame), 32'd3);
    #2 rst_n = 0;
    #1;
    chk("t6_mlp_en", 32'(o_mlp_en), 32'd0);
    chk("t6_busy", 32'(o_busy), 32'd0);
    chk("t6_res_frame", 32'(o_res_frame), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    tick();

    // Auto-rearm instance
    do_start();
    feed_beats(0, N);
    pulse_sort_final(2);
    do_cluster(10'h100, 10'h080);
    in_start = 1; tick(); in_start = 0;
    chk("t5_ar_mlp_en", 32'(a_mlp_en), 32'd1);
    chk("t5_ar_s_ready_classify", 32'(a_s_ready), 32'd0);
    do_mlp(4'd7, 24'h0000AA);
    chk("t5_ar_res_valid", 32'(a_res_valid), 32'd1);
    handshake();
    chk("t5_ar_s_ready", 32'(a_s_ready), 32'd1);
    chk("t5_ar_busy", 32'(a_busy), 32'd1);
    chk("t5_ar_res_frame", 32'(a_res_frame), 32'd1);
    chk("t5_main_s_ready", 32'(o_s_ready), 32'd0);
    tick();
    chk("t5_ar_s_ready_hold", 32'(a_s_ready), 32'd1);

    // Randomized traffic: brisk handshakes, then sluggish ones that provoke timeouts
    run_random(1500, 4);
    run_random(1500, 24);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
